// File: rtl/cntr_n.sv
// Loadable up/down counter with double-step history, programmable bound
// and wrap or saturate at the range edges.
module cntr_n #(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 2**WIDTH-1,
  parameter bit SAT     = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  output logic [2:0]       o_state,
  output logic             tc
);

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    LOAD = 3'b001,
    INC  = 3'b010,
    INC2 = 3'b011,
    DEC  = 3'b100,
    DEC2 = 3'b101
  } state_t;

  localparam int RW = WIDTH + 2;

  localparam logic signed [RW-1:0] MAXS  = RW'(MAX_VAL);
  localparam logic signed [RW-1:0] MAXP1 = RW'(MAX_VAL + 1);
  localparam logic signed [RW-1:0] P1    = RW'(1);
  localparam logic signed [RW-1:0] P2    = RW'(2);
  localparam logic signed [RW-1:0] M1    = -P1;
  localparam logic signed [RW-1:0] M2    = -P2;

  state_t                 nxt;
  logic signed [RW-1:0]   step;
  logic signed [RW-1:0]   cur;
  logic signed [RW-1:0]   ld;
  logic signed [RW-1:0]   r;
  logic signed [RW-1:0]   r_adj;
  logic [WIDTH-1:0]       cnt_d;
  logic                   tc_d;

  // Only a run of same-direction steps promotes to the double step;
  // unreachable codes fall into the single-step arm like IDLE.
  always_comb begin
    nxt = IDLE;
    unique case (1'b1)
      load:
        nxt = LOAD;
      !load && inc:
        nxt = (o_state == INC || o_state == INC2)
            ? INC2 : INC;
      !load && !inc:
        nxt = (o_state == DEC || o_state == DEC2)
            ? DEC2 : DEC;
    endcase
  end

  always_comb begin
    step = '0;
    unique case (nxt)
      INC:     step = P1;
      INC2:    step = P2;
      DEC:     step = M1;
      DEC2:    step = M2;
      default: step = '0;
    endcase
  end

  assign cur = signed'({2'b00, d_out});
  assign ld  = signed'({2'b00, d_in});
  assign r   = cur + step;

  // Loads clamp silently; only stepping out of range raises tc.
  always_comb begin
    r_adj = r;
    tc_d  = 1'b0;
    if (nxt == LOAD) begin
      r_adj = (ld > MAXS) ? MAXS : ld;
    end else if (r > MAXS) begin
      r_adj = SAT ? MAXS : r - MAXP1;
      tc_d  = 1'b1;
    end else if (r < 0) begin
      r_adj = SAT ? '0 : r + MAXP1;
      tc_d  = 1'b1;
    end
  end

  assign cnt_d = r_adj[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      o_state <= IDLE;
      d_out   <= '0;
      tc      <= 1'b0;
    end else if (en) begin
      o_state <= nxt;
      d_out   <= cnt_d;
      tc      <= tc_d;
    end
  end

endmodule

// File: tb/tb_cntr_n.sv
// Directed bench for cntr_n: a wrapping 8-bit instance and a
// saturating MAX_VAL=200 instance share one stimulus stream.
module tb_cntr_n;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic       inc = 1'b0;
  logic [7:0] d_in = '0;

  logic [7:0] w_out;
  logic [2:0] w_st;
  logic       w_tc;
  logic [7:0] s_out;
  logic [2:0] s_st;
  logic       s_tc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cntr_n #(.WIDTH(8)) u_wrap (
    .clk(clk), .reset(reset), .en(en),
    .load(load), .inc(inc), .d_in(d_in),
    .d_out(w_out), .o_state(w_st), .tc(w_tc)
  );

  cntr_n #(.WIDTH(8), .MAX_VAL(200), .SAT(1'b1)) u_sat (
    .clk(clk), .reset(reset), .en(en),
    .load(load), .inc(inc), .d_in(d_in),
    .d_out(s_out), .o_state(s_st), .tc(s_tc)
  );

  task automatic cyc(input logic r, input logic e,
                     input logic l, input logic i,
                     input logic [7:0] d);
    reset = r;
    en    = e;
    load  = l;
    inc   = i;
    d_in  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    cyc(1, 1, 1, 0, 8'h55);
    checks++;
    if ({w_out, w_st, w_tc} !== {8'h00, 3'b000, 1'b0}) begin
      $display("FAIL reset got=%h/%b/%b want=00/000/0",
               w_out, w_st, w_tc);
      failures++;
    end
    cyc(0, 1, 1, 0, 8'h55);
    checks++;
    if ({w_out, w_st, w_tc} !== {8'h55, 3'b001, 1'b0}) begin
      $display("FAIL reset_load got=%h/%b/%b want=55/001/0",
               w_out, w_st, w_tc);
      failures++;
    end
  endtask

  task automatic test_wrap_up;
    cyc(0, 1, 1, 0, 8'hFE);
    cyc(0, 1, 0, 1, 8'h00);
    checks++;
    if ({w_out, w_st, w_tc} !== {8'hFF, 3'b010, 1'b0}) begin
      $display("FAIL wrap_up1 got=%h/%b/%b want=ff/010/0",
               w_out, w_st, w_tc);
      failures++;
    end
    cyc(0, 1, 0, 1, 8'h00);
    checks++;
    if ({w_out, w_st, w_tc} !== {8'h01, 3'b011, 1'b1}) begin
      $display("FAIL wrap_up2 got=%h/%b/%b want=01/011/1",
               w_out, w_st, w_tc);
      failures++;
    end
    cyc(0, 0, 0, 1, 8'h00);
    checks++;
    if ({w_out, w_st, w_tc} !== {8'h01, 3'b011, 1'b1}) begin
      $display("FAIL tc_hold got=%h/%b/%b want=01/011/1",
               w_out, w_st, w_tc);
      failures++;
    end
    cyc(0, 1, 0, 1, 8'h00);
    checks++;
    if ({w_out, w_st, w_tc} !== {8'h03, 3'b011, 1'b0}) begin
      $display("FAIL wrap_up3 got=%h/%b/%b want=03/011/0",
               w_out, w_st, w_tc);
      failures++;
    end
  endtask

  task automatic test_wrap_down;
    cyc(0, 1, 1, 0, 8'h01);
    cyc(0, 1, 0, 0, 8'h00);
    checks++;
    if ({w_out, w_st, w_tc} !== {8'h00, 3'b100, 1'b0}) begin
      $display("FAIL wrap_dn1 got=%h/%b/%b want=00/100/0",
               w_out, w_st, w_tc);
      failures++;
    end
    cyc(0, 1, 0, 0, 8'h00);
    checks++;
    if ({w_out, w_st, w_tc} !== {8'hFE, 3'b101, 1'b1}) begin
      $display("FAIL wrap_dn2 got=%h/%b/%b want=fe/101/1",
               w_out, w_st, w_tc);
      failures++;
    end
    cyc(0, 1, 0, 1, 8'h00);
    checks++;
    if ({w_out, w_st, w_tc} !== {8'hFF, 3'b010, 1'b0}) begin
      $display("FAIL reversal got=%h/%b/%b want=ff/010/0",
               w_out, w_st, w_tc);
      failures++;
    end
  endtask

  task automatic test_saturate;
    cyc(0, 1, 1, 0, 8'd199);
    cyc(0, 1, 0, 1, 8'd0);
    checks++;
    if ({s_out, s_st, s_tc} !== {8'd200, 3'b010, 1'b0}) begin
      $display("FAIL sat1 got=%0d/%b/%b want=200/010/0",
               s_out, s_st, s_tc);
      failures++;
    end
    cyc(0, 1, 0, 1, 8'd0);
    checks++;
    if ({s_out, s_st, s_tc} !== {8'd200, 3'b011, 1'b1}) begin
      $display("FAIL sat2 got=%0d/%b/%b want=200/011/1",
               s_out, s_st, s_tc);
      failures++;
    end
    cyc(0, 1, 0, 1, 8'd0);
    checks++;
    if ({s_out, s_st, s_tc} !== {8'd200, 3'b011, 1'b1}) begin
      $display("FAIL sat3 got=%0d/%b/%b want=200/011/1",
               s_out, s_st, s_tc);
      failures++;
    end
    cyc(0, 1, 1, 0, 8'd250);
    checks++;
    if ({s_out, s_st, s_tc} !== {8'd200, 3'b001, 1'b0}) begin
      $display("FAIL sat_load got=%0d/%b/%b want=200/001/0",
               s_out, s_st, s_tc);
      failures++;
    end
    cyc(0, 1, 0, 0, 8'd0);
    cyc(0, 1, 1, 0, 8'd1);
    cyc(0, 1, 0, 0, 8'd0);
    cyc(0, 1, 0, 0, 8'd0);
    checks++;
    if ({s_out, s_st, s_tc} !== {8'd0, 3'b101, 1'b1}) begin
      $display("FAIL sat_low got=%0d/%b/%b want=0/101/1",
               s_out, s_st, s_tc);
      failures++;
    end
  endtask

  task automatic test_enable_priority;
    cyc(0, 1, 1, 0, 8'd7);
    cyc(0, 1, 0, 1, 8'd0);
    cyc(0, 1, 0, 1, 8'd0);
    checks++;
    if ({w_out, w_st, w_tc} !== {8'd10, 3'b011, 1'b0}) begin
      $display("FAIL en_setup got=%0d/%b/%b want=10/011/0",
               w_out, w_st, w_tc);
      failures++;
    end
    cyc(0, 0, 1, 0, 8'd99);
    cyc(0, 0, 0, 0, 8'd3);
    cyc(0, 0, 1, 1, 8'd42);
    checks++;
    if ({w_out, w_st, w_tc} !== {8'd10, 3'b011, 1'b0}) begin
      $display("FAIL en_hold got=%0d/%b/%b want=10/011/0",
               w_out, w_st, w_tc);
      failures++;
    end
    cyc(0, 1, 1, 1, 8'd7);
    checks++;
    if ({w_out, w_st, w_tc} !== {8'd7, 3'b001, 1'b0}) begin
      $display("FAIL load_prio got=%0d/%b/%b want=7/001/0",
               w_out, w_st, w_tc);
      failures++;
    end
    cyc(0, 1, 0, 1, 8'd0);
    checks++;
    if ({w_out, w_st, w_tc} !== {8'd8, 3'b010, 1'b0}) begin
      $display("FAIL hist_restart got=%0d/%b/%b want=8/010/0",
               w_out, w_st, w_tc);
      failures++;
    end
  endtask

  task automatic test_reset_mid;
    cyc(0, 1, 1, 0, 8'd43);
    cyc(0, 1, 0, 0, 8'd0);
    cyc(0, 1, 0, 0, 8'd0);
    checks++;
    if ({w_out, w_st, w_tc} !== {8'd40, 3'b101, 1'b0}) begin
      $display("FAIL mid_setup got=%0d/%b/%b want=40/101/0",
               w_out, w_st, w_tc);
      failures++;
    end
    cyc(1, 1, 0, 0, 8'd0);
    checks++;
    if ({w_out, w_st, w_tc} !== {8'd0, 3'b000, 1'b0}) begin
      $display("FAIL mid_reset got=%0d/%b/%b want=0/000/0",
               w_out, w_st, w_tc);
      failures++;
    end
    cyc(0, 1, 0, 0, 8'd0);
    checks++;
    if ({w_out, w_st, w_tc} !== {8'hFF, 3'b100, 1'b1}) begin
      $display("FAIL post_reset got=%h/%b/%b want=ff/100/1",
               w_out, w_st, w_tc);
      failures++;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_wrap_up;
    test_wrap_down;
    test_saturate;
    test_enable_priority;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
